// File: rtl/cdf53_lift_row_if.sv
// Triplet-in / coefficient-pair-out bundle for the CDF 5/3 row lifting stage.
// The master is the row serialiser side and the slave is the lifting stage.
interface cdf53_lift_row_if #(
  parameter int LENGTH = 16,
  parameter int DATA_W = 8
);
  localparam int NP    = LENGTH / 2;
  localparam int IDX_W = (NP > 1) ? $clog2(NP) : 1;

  logic                     in_valid;
  logic [DATA_W-1:0]        x0;
  logic [DATA_W-1:0]        x1;
  logic [DATA_W-1:0]        x2;
  logic                     out_valid;
  logic signed [DATA_W+1:0] low;
  logic signed [DATA_W:0]   high;
  logic                     row_done;
  logic [IDX_W-1:0]         pair_idx;

  modport master (
    output in_valid, x0, x1, x2,
    input  out_valid, low, high, row_done, pair_idx
  );

  modport slave (
    input  in_valid, x0, x1, x2,
    output out_valid, low, high, row_done, pair_idx
  );
endinterface

// File: rtl/cdf53_lift_row.sv
// Single-level CDF 5/3 integer lifting of one row, one triplet in and one (s,d) pair out per valid cycle.
// Optional macro CDF_CLAMP_EN clamps low to [0, 2^DATA_W-1] and high to the DATA_W signed range.
module cdf53_lift_row #(
  parameter int LENGTH = 16,
  parameter int DATA_W = 8
) (
  input  logic             clk,
  input  logic             resetn,
  cdf53_lift_row_if.slave  bus
);
  localparam int NP    = LENGTH / 2;
  localparam int IDX_W = (NP > 1) ? $clog2(NP) : 1;
  localparam int W3    = DATA_W + 3;
  localparam int LW    = DATA_W + 2;
  localparam int HW    = DATA_W + 1;
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NP - 1);
  localparam logic signed [W3-1:0] ROUND    = W3'(2);
`ifdef CDF_CLAMP_EN
  localparam logic signed [W3-1:0] LOW_MAX  = W3'((1 << DATA_W) - 1);
  localparam logic signed [W3-1:0] HIGH_MAX = W3'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [W3-1:0] HIGH_MIN = -W3'(1 << (DATA_W - 1));
`endif

  typedef enum logic {ROW_START, IN_ROW} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic signed [HW-1:0]  d_prev_q, d_prev_d;
  logic signed [LW-1:0]  low_q, low_d;
  logic signed [HW-1:0]  high_q, high_d;
  logic [IDX_W-1:0]      pair_idx_q, pair_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic                  row_done_q, row_done_d;

  logic [HW-1:0]         even_sum;
  logic [HW-1:0]         even_half;
  logic signed [W3-1:0]  d_w;
  logic signed [W3-1:0]  dl_w;
  logic signed [W3-1:0]  upd_w;
  logic signed [LW-1:0]  low_val;
  logic signed [HW-1:0]  high_val;
`ifdef CDF_CLAMP_EN
  logic signed [W3-1:0]  s_w;
`endif

  // Predict and update datapath, all evaluated in the input cycle.
  always_comb begin
    even_sum  = {1'b0, bus.x0} + {1'b0, bus.x2};
    even_half = even_sum >> 1;
    d_w       = $signed({3'b000, bus.x1}) - $signed({2'b00, even_half});
    // Symmetric extension at the row start: d[-1] mirrors d[0].
    dl_w      = (state_q == ROW_START) ? d_w : W3'(d_prev_q);
    upd_w     = (dl_w + d_w + ROUND) >>> 2;
`ifdef CDF_CLAMP_EN
    s_w = $signed({3'b000, bus.x0}) + upd_w;
    if (s_w < 0) begin
      low_val = '0;
    end else if (s_w > LOW_MAX) begin
      low_val = LW'(LOW_MAX);
    end else begin
      low_val = LW'(s_w);
    end
    if (d_w < HIGH_MIN) begin
      high_val = HW'(HIGH_MIN);
    end else if (d_w > HIGH_MAX) begin
      high_val = HW'(HIGH_MAX);
    end else begin
      high_val = HW'(d_w);
    end
`else
    low_val  = LW'($signed({3'b000, bus.x0}) + upd_w);
    high_val = HW'(d_w);
`endif
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    d_prev_d    = d_prev_q;
    low_d       = low_q;
    high_d      = high_q;
    pair_idx_d  = pair_idx_q;
    out_valid_d = 1'b0;
    row_done_d  = 1'b0;
    if (bus.in_valid) begin
      low_d       = low_val;
      high_d      = high_val;
      out_valid_d = 1'b1;
      pair_idx_d  = idx_q;
      // The unclamped d feeds the next update so the lifting stays exact.
      d_prev_d    = HW'(d_w);
      row_done_d  = (idx_q == LAST_IDX);
      if (idx_q == LAST_IDX) begin
        idx_d   = '0;
        state_d = ROW_START;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = IN_ROW;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ROW_START;
      idx_q       <= '0;
      d_prev_q    <= '0;
      low_q       <= '0;
      high_q      <= '0;
      pair_idx_q  <= '0;
      out_valid_q <= 1'b0;
      row_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      d_prev_q    <= d_prev_d;
      low_q       <= low_d;
      high_q      <= high_d;
      pair_idx_q  <= pair_idx_d;
      out_valid_q <= out_valid_d;
      row_done_q  <= row_done_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.low       = low_q;
  assign bus.high      = high_q;
  assign bus.row_done  = row_done_q;
  assign bus.pair_idx  = pair_idx_q;
endmodule

// File: tb/tb_cdf53_lift_row.sv
// Randomized and directed bench for cdf53_lift_row against a whole-row arithmetic model.
// Honours CDF_CLAMP_EN in the model when the macro is defined for the build.
module tb_cdf53_lift_row;
  localparam int LENGTH = 8;
  localparam int DATA_W = 8;
  localparam int NP     = LENGTH / 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  cdf53_lift_row_if #(.LENGTH(LENGTH), .DATA_W(DATA_W)) bus ();

  cdf53_lift_row #(.LENGTH(LENGTH), .DATA_W(DATA_W)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int row_x [LENGTH];
  int xm    [LENGTH+1];
  int exp_lo[NP];
  int exp_hi[NP];
  int last_lo, last_hi, last_idx;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floor4(input int v);
    return (v >= 0) ? v / 4 : -((3 - v) / 4);
  endfunction

  // Whole-row lifting from the textbook formulas, mirror-extended at both ends.
  task automatic model_row();
    int d[NP];
    int s, dl;
    for (int k = 0; k < LENGTH; k++) xm[k] = row_x[k];
    xm[LENGTH] = row_x[LENGTH-1];
    for (int i = 0; i < NP; i++)
      d[i] = xm[2*i+1] - (xm[2*i] + xm[2*i+2]) / 2;
    for (int i = 0; i < NP; i++) begin
      dl = (i == 0) ? d[0] : d[i-1];
      s  = xm[2*i] + floor4(dl + d[i] + 2);
      exp_lo[i] = s;
      exp_hi[i] = d[i];
`ifdef CDF_CLAMP_EN
      if (exp_lo[i] < 0) exp_lo[i] = 0;
      if (exp_lo[i] > (1 << DATA_W) - 1) exp_lo[i] = (1 << DATA_W) - 1;
      if (exp_hi[i] < -(1 << (DATA_W-1))) exp_hi[i] = -(1 << (DATA_W-1));
      if (exp_hi[i] > (1 << (DATA_W-1)) - 1) exp_hi[i] = (1 << (DATA_W-1)) - 1;
`endif
    end
  endtask

  task automatic drive(input logic v, input int a, input int b, input int c);
    bus.in_valid = v;
    bus.x0 = DATA_W'(a);
    bus.x1 = DATA_W'(b);
    bus.x2 = DATA_W'(c);
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input string tag, input int i);
    drive(1'b1, xm[2*i], xm[2*i+1], xm[2*i+2]);
    check_eq({tag, ".valid"}, int'(bus.out_valid), 1);
    check_eq({tag, ".low"}, $signed(bus.low), exp_lo[i]);
    check_eq({tag, ".high"}, $signed(bus.high), exp_hi[i]);
    check_eq({tag, ".idx"}, int'(bus.pair_idx), i);
    check_eq({tag, ".done"}, int'(bus.row_done), (i == NP-1) ? 1 : 0);
    $display("pair %s i=%0d x=(%0d,%0d,%0d) low=%0d high=%0d", tag, i,
             xm[2*i], xm[2*i+1], xm[2*i+2], $signed(bus.low), $signed(bus.high));
    last_lo = exp_lo[i];
    last_hi = exp_hi[i];
    last_idx = i;
  endtask

  task automatic idle(input string tag);
    drive(1'b0, $urandom_range(255), $urandom_range(255), $urandom_range(255));
    check_eq({tag, ".idle_valid"}, int'(bus.out_valid), 0);
    check_eq({tag, ".idle_done"}, int'(bus.row_done), 0);
    check_eq({tag, ".hold_low"}, $signed(bus.low), last_lo);
    check_eq({tag, ".hold_high"}, $signed(bus.high), last_hi);
    check_eq({tag, ".hold_idx"}, int'(bus.pair_idx), last_idx);
  endtask

  // gap_mode: 0 back-to-back, 1 random gaps, 2 three idles between pairs 1 and 2.
  task automatic run_row(input string tag, input int gap_mode);
    model_row();
    for (int i = 0; i < NP; i++) begin
      send_pair(tag, i);
      if (gap_mode == 1 && $urandom_range(2) == 0)
        repeat ($urandom_range(3, 1)) idle(tag);
      if (gap_mode == 2 && i == 1)
        repeat (3) idle(tag);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".valid"}, int'(bus.out_valid), 0);
    check_eq({tag, ".done"}, int'(bus.row_done), 0);
    check_eq({tag, ".low"}, $signed(bus.low), 0);
    check_eq({tag, ".high"}, $signed(bus.high), 0);
    check_eq({tag, ".idx"}, int'(bus.pair_idx), 0);
    last_lo = 0;
    last_hi = 0;
    last_idx = 0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.x0 = '0;
    bus.x1 = '0;
    bus.x2 = '0;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    check_zero("reset");
    resetn = 1'b1;

    for (int k = 0; k < LENGTH; k++) row_x[k] = 100;
    run_row("flat", 0);
    for (int k = 0; k < LENGTH; k++) row_x[k] = 10 * k;
    run_row("ramp", 0);
    for (int k = 0; k < LENGTH; k++) row_x[k] = (k % 2) ? 255 : 0;
    run_row("alt", 0);
    for (int k = 0; k < LENGTH; k++) row_x[k] = (k % 2) ? 0 : 255;
    run_row("inv", 0);
    for (int k = 0; k < LENGTH; k++) row_x[k] = (k % 4 == 0) ? 0 : 255;
    run_row("mixed", 0);
    run_row("mixed_gap", 2);

    // Abort a row after pair 1; the next triplet must restart at pair 0.
    for (int k = 0; k < LENGTH; k++) row_x[k] = $urandom_range(255);
    model_row();
    send_pair("abort", 0);
    send_pair("abort", 1);
    resetn = 1'b0;
    drive(1'b0, 0, 0, 0);
    check_zero("midreset");
    resetn = 1'b1;
    for (int k = 0; k < LENGTH; k++) row_x[k] = $urandom_range(255);
    run_row("restart", 0);

    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < LENGTH; k++) row_x[k] = $urandom_range(255);
      run_row($sformatf("rand%0d", r), (r % 2 == 0) ? 0 : 1);
    end
    idle("tail");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
